// File: rtl/pcie_dllp_crc16_engine.sv
`default_nettype none
// ============================================================================
// Module      : pcie_dllp_crc16_engine
// Description : Streaming CRC-16 generator/checker for PCIe DLLPs. Beats of
//               DATA_W bits pass through a single output register (latency 1)
//               while a 16-bit accumulator folds in every byte (byte 0 =
//               in_data MSB byte, LSB of each byte first). On the last beat of
//               a frame the bit-reversed, optionally complemented CRC is
//               presented on crc, and crc_ok reports the match against chk_crc.
// Ports       : clk, reset (sync, active-low)
//               in_valid/in_ready/in_first/in_last/in_data : input stream
//               chk_en/chk_crc : check-mode control, sampled with in_last
//               out_valid/out_ready/out_data/out_last      : output stream
//               crc/crc_ok     : result, valid with out_valid & out_last
//               seq_err        : one-cycle pulse on a framing violation
// Revision    : 1.0 - initial release
// ============================================================================
module pcie_dllp_crc16_engine #(
    parameter int          DATA_W     = 32,
    parameter logic [15:0] SEED       = 16'hFFFF,
    parameter logic [15:0] POLY       = 16'h100B,
    parameter bit          INVERT_OUT = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_first,
    input  logic              in_last,
    input  logic [DATA_W-1:0] in_data,
    input  logic              chk_en,
    input  logic [15:0]       chk_crc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [15:0]       crc,
    output logic              crc_ok,
    output logic              seq_err
);

    localparam int NBYTES = DATA_W / 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

    state_t              state_q,     state_d;
    logic [15:0]         acc_q,       acc_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q,  out_data_d;
    logic                out_last_q,  out_last_d;
    logic [15:0]         crc_q,       crc_d;
    logic                crc_ok_q,    crc_ok_d;
    logic                seq_err_q,   seq_err_d;

    logic                accept;
    logic [15:0]         acc_start;
    logic [15:0]         acc_next;
    logic [15:0]         crc_next;

    // Fold a whole beat into the accumulator, byte 0 (MSB byte) first and
    // bit 0 of each byte first, one LFSR step per bit.
    function automatic logic [15:0] crc_beat(input logic [15:0]       acc_in,
                                             input logic [DATA_W-1:0] data);
        logic [15:0] a;
        logic        fb;
        a = acc_in;
        for (int b = 0; b < NBYTES; b++) begin
            for (int i = 0; i < 8; i++) begin
                fb = a[15] ^ data[DATA_W - 8 - 8*b + i];
                a  = {a[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
            end
        end
        return a;
    endfunction

    // Bit-reverse each byte of the accumulator so the CRC goes out in the
    // same LSB-first wire order as the payload.
    function automatic logic [15:0] crc_final(input logic [15:0] a);
        logic [15:0] r;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) begin
                r[8*k + i] = a[8*k + 7 - i];
            end
        end
        return INVERT_OUT ? ~r : r;
    endfunction

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;

    // in_first always restarts from SEED, even when a frame is still open.
    assign acc_start = in_first ? SEED : acc_q;
    assign acc_next  = crc_beat(acc_start, in_data);
    assign crc_next  = crc_final(acc_next);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        crc_d       = crc_q;
        crc_ok_d    = crc_ok_q;
        seq_err_d   = 1'b0;

        if (accept) begin
            if (!in_first && (state_q == ST_IDLE)) begin
                // Orphan beat: flag it and drop it without touching acc.
                seq_err_d = 1'b1;
            end else begin
                // A new in_first while a frame is open abandons that frame.
                if (in_first && (state_q == ST_ACC)) begin
                    seq_err_d = 1'b1;
                end
                acc_d       = acc_next;
                out_valid_d = 1'b1;
                out_data_d  = in_data;
                out_last_d  = in_last;
                if (in_last) begin
                    state_d  = ST_IDLE;
                    crc_d    = crc_next;
                    crc_ok_d = chk_en ? (crc_next == chk_crc) : 1'b1;
                end else begin
                    state_d  = ST_ACC;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= SEED;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            crc_q       <= 16'h0000;
            crc_ok_q    <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            crc_q       <= crc_d;
            crc_ok_q    <= crc_ok_d;
            seq_err_q   <= seq_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign crc       = crc_q;
    assign crc_ok    = crc_ok_q;
    assign seq_err   = seq_err_q;

endmodule
`default_nettype wire
